core_controller: RTL and testbench



---
 rtl/core_controller_pkg.sv | 51 +++++
 rtl/next_pc_gen.sv | 47 ++++
 rtl/core_controller.sv | 145 ++++++++++++++
 tb/tb_core_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_controller_pkg.sv
// ---------------------------------------------------------------------------
// core_controller_pkg
//
// Shared definitions for the TinyRisc-V multi-cycle sequencer. The decoder
// and the controller both import this package, so the opcode values and the
// controller state codes have a single definition.
//
// Contents:
//   CTRL_STATE_WIDTH  width of the controller state register
//   ctrl_state_t      controller states (FETCH .. HALT)
//   OPC_*             7-bit major opcodes of the RV32I base set
//   is_legal_opcode   opcode is one the controller knows how to sequence
//   is_mem_opcode     opcode needs a data-memory access (LOAD / STORE)
// ---------------------------------------------------------------------------
package core_controller_pkg;

    localparam int CTRL_STATE_WIDTH = 3;

    typedef enum logic [CTRL_STATE_WIDTH-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Anything outside this set (including the all-zero word) stops the core.
    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: is_legal_opcode = 1'b1;
            default:                                 is_legal_opcode = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_opcode(input logic [6:0] opcode);
        is_mem_opcode = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/next_pc_gen.sv
// ---------------------------------------------------------------------------
// next_pc_gen
//
// Purely combinational next-PC selection used during write-back.
//
// Ports:
//   pc            in  32  PC of the instruction being retired
//   imm           in  32  decoder immediate
//   rs1_data      in  32  register-file read port 1 (JALR base)
//   opcode        in  7   major opcode of the instruction being retired
//   branch_taken  in  1   compare outcome (ALU result bit 0)
//   next_pc       out 32  PC of the following instruction
//   misaligned    out 1   next_pc is not word aligned
// ---------------------------------------------------------------------------
module next_pc_gen
    import core_controller_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] jalr_pc;

    // All additions wrap modulo 2^32. JALR clears bit 0 of its target, but
    // bit 1 is left alone so a half-word aligned target is still caught.
    always_comb begin
        seq_pc  = pc + 32'd4;
        rel_pc  = pc + imm;
        jalr_pc = (rs1_data + imm) & ~32'h1;
        next_pc = seq_pc;
        case (opcode)
            OPC_JAL:    next_pc = rel_pc;
            OPC_JALR:   next_pc = jalr_pc;
            OPC_BRANCH: next_pc = branch_taken ? rel_pc : seq_pc;
            default:    next_pc = seq_pc;
        endcase
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/core_controller.sv
// ---------------------------------------------------------------------------
// core_controller
//
// Multi-cycle sequencer for the TinyRisc-V core. Owns the PC and the
// instruction register, runs the instruction- and data-memory req/ack
// handshakes and walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. A bad opcode or a misaligned
// next PC parks the core in HALT until reset.
//
// Parameters:
//   RESET_PC     PC loaded on reset
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch handshake
//   ir, pc                   latched instruction and current PC
//   imm, wr_reg              from the decoder
//   rs1_data, rs2_data       register-file read ports
//   alu_result               ALU output (bit 0 = branch compare outcome)
//   dmem_req/we/addr/wdata   data access request
//   dmem_ack/rdata           data access completion
//   rd_we, wb_data           register-file write strobe and value
//   halted                   sticky halt flag
//   instret                  retired-instruction counter
// ---------------------------------------------------------------------------
module core_controller
    import core_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        wr_reg,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rd_we,
    output logic [31:0] wb_data,
    output logic        halted,
    output logic [31:0] instret
);

    ctrl_state_t state;
    logic [6:0]  opcode;
    logic [31:0] result_q;
    logic [31:0] next_pc;
    logic        misaligned;

    assign opcode = ir[6:0];

    next_pc_gen u_next_pc_gen (
        .pc           (pc),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .opcode       (opcode),
        .branch_taken (result_q[0]),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    // Requests and strobes are pure state decodes so a zero-wait ack can be
    // answered in the same cycle. Qualifying them with rst makes a reset
    // asserted mid-handshake withdraw the request immediately, not at the
    // next edge.
    assign imem_req  = !rst && (state == ST_FETCH);
    assign dmem_req  = !rst && (state == ST_MEM);
    assign dmem_we   = dmem_req && (opcode == OPC_STORE);
    assign rd_we     = !rst && (state == ST_WB) && wr_reg;
    assign halted    = (state == ST_HALT);
    assign imem_addr = pc;
    assign dmem_addr = result_q;

    // Main sequencer. wb_data is loaded with the ALU result in EXEC and
    // overwritten with the load data in MEM, so in WB it already holds the
    // correct write-back value. An ack that arrives while rst is high is
    // never seen because the reset branch wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= 32'h0;
            instret    <= 32'h0;
            result_q   <= 32'h0;
            dmem_wdata <= 32'h0;
            wb_data    <= 32'h0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= is_legal_opcode(opcode) ? ST_EXEC : ST_HALT;
                end
                ST_EXEC: begin
                    result_q   <= alu_result;
                    wb_data    <= alu_result;
                    dmem_wdata <= rs2_data;
                    state      <= is_mem_opcode(opcode) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (opcode == OPC_LOAD) begin
                            wb_data <= dmem_rdata;
                        end
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    // A misaligned target stops the core before the PC or
                    // the retire count move, leaving the faulting PC visible.
                    if (misaligned) begin
                        state <= ST_HALT;
                    end else begin
                        pc      <= next_pc;
                        instret <= instret + 32'd1;
                        state   <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_controller.sv
// ---------------------------------------------------------------------------
// tb_core_controller
//
// Directed bench for core_controller. The bench plays the role of both
// memories, the decoder and the ALU: each instruction is given with the
// immediate, write flag and ALU result a correct datapath would produce,
// and the expected PC / counter / write-back values are hand-computed.
// ---------------------------------------------------------------------------
module tb_core_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        wr_reg;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_result;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        rd_we;
    logic [31:0] wb_data;
    logic        halted;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    // Observations gathered by run_instr for one instruction.
    int          o_cycles;
    int          o_dreq;
    int          o_rdwe;
    int          o_rdwe_cyc;
    logic [31:0] o_wb;
    logic [31:0] o_daddr;
    logic [31:0] o_faddr;
    bit          o_we;
    bit          o_both;
    bit          o_halt;
    bit          o_timeout;

    core_controller #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .pc         (pc),
        .imm        (imm),
        .wr_reg     (wr_reg),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .alu_result (alu_result),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rd_we      (rd_we),
        .wb_data    (wb_data),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Runs one instruction starting in FETCH, just after a falling edge.
    // Acks are decided 1 time unit after each falling edge, so zero-wait
    // acks coincide with the request. Returns just after the falling edge
    // that starts the next FETCH, or on halt, or after a cycle budget.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] alu,
                             input logic [31:0] immv, input logic wr,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input int iwait, input int dwait,
                             input logic [31:0] drd);
        int iw;
        int dw;
        bit left;
        iw = 0; dw = 0; left = 0;
        imem_rdata = instr; alu_result = alu; imm = immv; wr_reg = wr;
        rs1_data = rs1; rs2_data = rs2; dmem_rdata = drd;
        o_cycles = 0; o_dreq = 0; o_rdwe = 0; o_rdwe_cyc = 0;
        o_wb = 32'h0; o_daddr = 32'h0; o_faddr = 32'h0;
        o_we = 0; o_both = 0; o_halt = 0; o_timeout = 1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (halted) begin
                o_halt = 1; o_timeout = 0;
                break;
            end
            if (left && imem_req) begin
                o_timeout = 0;
                break;
            end
            o_cycles++;
            if (imem_req && dmem_req) o_both = 1;
            if (imem_req) begin
                if (o_cycles == 1) o_faddr = imem_addr;
                if (iw >= iwait) imem_ack = 1'b1;
                else begin imem_ack = 1'b0; iw++; end
            end else begin
                imem_ack = 1'b0;
                left = 1;
            end
            if (dmem_req) begin
                if (o_dreq == 0) o_daddr = dmem_addr;
                o_dreq++;
                if (dmem_we) o_we = 1;
                if (dw >= dwait) dmem_ack = 1'b1;
                else begin dmem_ack = 1'b0; dw++; end
            end else begin
                dmem_ack = 1'b0;
            end
            if (rd_we) begin
                o_rdwe++;
                o_wb = wb_data;
                o_rdwe_cyc = o_cycles;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ack = 0; dmem_ack = 0; imem_rdata = 0; imm = 0;
        wr_reg = 0; rs1_data = 0; rs2_data = 0; alu_result = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL reset_dmem got req=%b we=%b exp=0", dmem_req, dmem_we); end
        total++; if (rd_we !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_flags got rd_we=%b halted=%b exp=0", rd_we, halted); end
        total++; if (pc !== 32'h0 || ir !== 32'h0) begin bad++; $display("FAIL reset_pc_ir got pc=%h ir=%h exp=0", pc, ir); end
        total++; if (instret !== 32'h0 || wb_data !== 32'h0) begin bad++; $display("FAIL reset_counters got instret=%h wb=%h exp=0", instret, wb_data); end
        total++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin bad++; $display("FAIL reset_dmem_regs got addr=%h wdata=%h exp=0", dmem_addr, dmem_wdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_fetch got req=%b addr=%h exp=1/0", imem_req, imem_addr); end
    endtask

    // addi x1,x0,5 at 0x0, zero-wait fetch.
    task automatic test_alu_op;
        run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (o_timeout || o_cycles != 4) begin bad++; $display("FAIL addi_latency got cycles=%0d timeout=%0b exp=4", o_cycles, o_timeout); end
        total++; if (o_rdwe != 1 || o_rdwe_cyc != 4) begin bad++; $display("FAIL addi_rd_we got pulses=%0d cycle=%0d exp=1@4", o_rdwe, o_rdwe_cyc); end
        total++; if (o_wb !== 32'd5) begin bad++; $display("FAIL addi_wb got=%h exp=5", o_wb); end
        total++; if (pc !== 32'h4 || instret !== 32'd1) begin bad++; $display("FAIL addi_pc got pc=%h instret=%0d exp=4/1", pc, instret); end
        total++; if (ir !== 32'h0050_0093 || o_dreq != 0) begin bad++; $display("FAIL addi_ir got ir=%h dreq=%0d exp=00500093/0", ir, o_dreq); end
    endtask

    // lw at 0x4 with three dmem wait cycles.
    task automatic test_load_wait;
        run_instr(32'h0000_a103, 32'h20, 32'h0, 1'b1, 32'h20, 32'h0, 0, 3, 32'hDEAD_BEEF);
        total++; if (o_timeout || o_cycles != 8) begin bad++; $display("FAIL lw_latency got cycles=%0d timeout=%0b exp=8", o_cycles, o_timeout); end
        total++; if (o_dreq != 4 || o_we) begin bad++; $display("FAIL lw_dmem_req got cycles=%0d we=%0b exp=4/0", o_dreq, o_we); end
        total++; if (o_daddr !== 32'h20 || o_faddr !== 32'h4) begin bad++; $display("FAIL lw_addr got daddr=%h faddr=%h exp=20/4", o_daddr, o_faddr); end
        total++; if (o_wb !== 32'hDEAD_BEEF || o_rdwe != 1) begin bad++; $display("FAIL lw_wb got=%h pulses=%0d exp=deadbeef/1", o_wb, o_rdwe); end
        total++; if (pc !== 32'h8 || instret !== 32'd2 || o_both) begin bad++; $display("FAIL lw_pc got pc=%h instret=%0d both=%0b exp=8/2/0", pc, instret, o_both); end
    endtask

    // sw at 0x8, zero-wait dmem, then addi at 0xC to reach 0x10.
    task automatic test_store;
        run_instr(32'h0020_a023, 32'h40, 32'h0, 1'b0, 32'h40, 32'h1234, 0, 0, 32'h0);
        total++; if (o_timeout || o_cycles != 5) begin bad++; $display("FAIL sw_latency got cycles=%0d exp=5", o_cycles); end
        total++; if (o_dreq != 1 || !o_we || o_daddr !== 32'h40) begin bad++; $display("FAIL sw_dmem got req=%0d we=%0b addr=%h exp=1/1/40", o_dreq, o_we, o_daddr); end
        total++; if (dmem_wdata !== 32'h1234 || o_rdwe != 0) begin bad++; $display("FAIL sw_wdata got=%h rd_we=%0d exp=1234/0", dmem_wdata, o_rdwe); end
        total++; if (pc !== 32'hC || instret !== 32'd3) begin bad++; $display("FAIL sw_pc got pc=%h instret=%0d exp=c/3", pc, instret); end
        run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h10 || instret !== 32'd4) begin bad++; $display("FAIL addi2_pc got pc=%h instret=%0d exp=10/4", pc, instret); end
    endtask

    // beq taken at 0x10 (imm -8), JAL +8 back to 0x10, beq not taken.
    task automatic test_branch;
        run_instr(32'h0000_0063, 32'h1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h8 || o_rdwe != 0 || o_cycles != 4) begin bad++; $display("FAIL beq_taken got pc=%h rd_we=%0d cycles=%0d exp=8/0/4", pc, o_rdwe, o_cycles); end
        run_instr(32'h0000_006F, 32'hC, 32'h8, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h10 || o_wb !== 32'hC || instret !== 32'd6) begin bad++; $display("FAIL jal got pc=%h wb=%h instret=%0d exp=10/c/6", pc, o_wb, instret); end
        run_instr(32'h0000_0063, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h14 || o_rdwe != 0 || instret !== 32'd7) begin bad++; $display("FAIL beq_not_taken got pc=%h rd_we=%0d instret=%0d exp=14/0/7", pc, o_rdwe, instret); end
    endtask

    // JALR clears bit 0, fetch with wait states, then a misaligned JAL halts.
    task automatic test_jumps;
        bit active;
        run_instr(32'h0000_0067, 32'h18, 32'h0, 1'b1, 32'h101, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h100 || instret !== 32'd8) begin bad++; $display("FAIL jalr got pc=%h instret=%0d exp=100/8", pc, instret); end
        run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 2, 0, 32'h0);
        total++; if (o_cycles != 6 || o_faddr !== 32'h100 || pc !== 32'h104) begin bad++; $display("FAIL imem_wait got cycles=%0d faddr=%h pc=%h exp=6/100/104", o_cycles, o_faddr, pc); end
        run_instr(32'h0000_006F, 32'h108, 32'h6, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (!o_halt || o_cycles != 4) begin bad++; $display("FAIL jal_misaligned got halt=%0b cycles=%0d exp=1/4", o_halt, o_cycles); end
        total++; if (pc !== 32'h104 || instret !== 32'd9) begin bad++; $display("FAIL halt_state got pc=%h instret=%0d exp=104/9", pc, instret); end
        active = 0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (imem_req || dmem_req || rd_we || !halted) active = 1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        total++; if (active) begin bad++; $display("FAIL halt_quiet got activity=1 exp=0"); end
    endtask

    task automatic test_illegal;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h4 || instret !== 32'd1 || halted) begin bad++; $display("FAIL restart_addi got pc=%h instret=%0d halted=%b exp=4/1/0", pc, instret, halted); end
        run_instr(32'h0000_0000, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (!o_halt || o_cycles != 2 || o_rdwe != 0) begin bad++; $display("FAIL illegal_halt got halt=%0b cycles=%0d rd_we=%0d exp=1/2/0", o_halt, o_cycles, o_rdwe); end
        total++; if (instret !== 32'd1 || pc !== 32'h4) begin bad++; $display("FAIL illegal_state got instret=%0d pc=%h exp=1/4", instret, pc); end
    endtask

    task automatic test_reset_mid_access;
        bit reached;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        imem_rdata = 32'h0000_a103; alu_result = 32'h30; imm = 32'h0; wr_reg = 1'b1;
        dmem_rdata = 32'hCAFE_F00D; dmem_ack = 1'b0;
        reached = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (dmem_req) begin
                reached = 1;
                break;
            end
            imem_ack = imem_req;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        total++; if (!reached) begin bad++; $display("FAIL mid_reach_mem got dmem_req=0 exp=1"); end
        dmem_ack = 1'b1;
        rst = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop got dmem=%b imem=%b exp=0/0", dmem_req, imem_req); end
        @(posedge clk);
        #1;
        total++; if (instret !== 32'd0 || wb_data !== 32'h0 || pc !== 32'h0) begin bad++; $display("FAIL mid_reset_regs got instret=%0d wb=%h pc=%h exp=0/0/0", instret, wb_data, pc); end
        @(negedge clk);
        dmem_ack = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instret !== 32'd0) begin bad++; $display("FAIL mid_restart got req=%b addr=%h instret=%0d exp=1/0/0", imem_req, imem_addr, instret); end
        run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b1, 32'h0, 32'h0, 0, 0, 32'h0);
        total++; if (pc !== 32'h4 || instret !== 32'd1) begin bad++; $display("FAIL mid_after got pc=%h instret=%0d exp=4/1", pc, instret); end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
